exc_source: RTL and testbench

Exception request initiator for the single-cycle LEGv8 core with exceptions. It collects up to NSRC asynchronous-event sources into a pending register, picks the highest-priority one, and drives the core's exception-handling input pair `Exc` and `EStatus`. It holds `Exc` until the core acknowledges with `ExcAck`, then blocks further requests until the handler returns with `ERet`. It is the requesting end of the Exc/ExcAck/ERet handshake, and it sits between the event sources and the processor top level.

---
 rtl/exc_source.sv | 207 ++++++++++++++++++++
 tb/tb_exc_source.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_source.sv
// ----------------------------------------------------------------------------
// exc_source
//
// Exception request initiator for the single-cycle LEGv8 core. Rising edges
// on the irq lines are latched into a pending register. The lowest pending
// index is chosen and presented to the core on the Exc/EStatus pair. The
// block then runs the Exc/ExcAck/ERet handshake:
//   IDLE    -> REQ      ien=1 and something pending (EStatus = winner + 1)
//   REQ     -> SERVICE  ExcAck sampled high (winner's pending bit cleared)
//   SERVICE -> IDLE     ERet sampled high (EStatus back to 0)
//
// Optional feature, enabled by defining EXC_SOURCE_TIMEOUT_EN:
//   A REQ that is not acknowledged within TIMEOUT cycles is withdrawn
//   (back to IDLE, pending bit kept for retry), and the sticky timeout_err
//   output is set. Without the macro, REQ waits indefinitely and the
//   timeout_err port does not exist.
//
// Parameters:
//   NSRC        number of event sources, 1..15
//   TIMEOUT     REQ cycles allowed before withdrawal (macro builds only)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   irq          in   NSRC event lines, rising edge = event
//   ien          in   global enable, gates only IDLE -> REQ
//   ExcAck       in   core acknowledge (level)
//   ERet         in   core exception return (single-cycle pulse)
//   Exc          out  exception request, registered
//   EStatus      out  cause code = selected index + 1, 0 = none
//   pending      out  latched, not-yet-serviced events
//   busy         out  high in REQ or SERVICE
//   timeout_err  out  sticky timeout flag (macro builds only)
// ----------------------------------------------------------------------------
module exc_source #(
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            ien,
    input  logic            ExcAck,
    input  logic            ERet,
    output logic            Exc,
    output logic [3:0]      EStatus,
    output logic [NSRC-1:0] pending,
    output logic            busy
`ifdef EXC_SOURCE_TIMEOUT_EN
    ,
    output logic            timeout_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Index of the lowest set bit; only meaningful when v is non-zero.
    function automatic logic [3:0] lowest_idx(input logic [NSRC-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_e          state_q, state_d;
    logic [NSRC-1:0] irq_q, irq_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [3:0]      sel_q, sel_d;
    logic [3:0]      estatus_q, estatus_d;
    logic            exc_q, exc_d;
    logic            busy_q, busy_d;

    logic [NSRC-1:0] event_s;
    logic [NSRC-1:0] clr_s;
    logic [3:0]      winner_s;

`ifdef EXC_SOURCE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc_s;
    logic          terr_q, terr_d;
`endif

    // Next-state, pending and output computation.
    always_comb begin
        event_s   = irq & ~irq_q;
        irq_d     = irq;
        winner_s  = lowest_idx(pending_q);
        state_d   = state_q;
        sel_d     = sel_q;
        estatus_d = estatus_q;
        clr_s     = '0;
`ifdef EXC_SOURCE_TIMEOUT_EN
        cnt_d     = cnt_q;
        cnt_inc_s = cnt_q + CW'(1);
        terr_d    = terr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ien && (pending_q != '0)) begin
                    state_d   = ST_REQ;
                    sel_d     = winner_s;
                    estatus_d = winner_s + 4'd1;
`ifdef EXC_SOURCE_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ExcAck) begin
                    // Acknowledge beats a timeout landing on the same cycle.
                    state_d = ST_SERVICE;
                    for (int i = 0; i < NSRC; i++) begin
                        clr_s[i] = (sel_q == 4'(i));
                    end
`ifdef EXC_SOURCE_TIMEOUT_EN
                end else if (cnt_inc_s == CW'(TIMEOUT)) begin
                    // Withdraw; the pending bit stays so the source is retried.
                    state_d   = ST_IDLE;
                    estatus_d = 4'd0;
                    terr_d    = 1'b1;
                    cnt_d     = cnt_inc_s;
                end else begin
                    state_d = ST_REQ;
                    cnt_d   = cnt_inc_s;
                end
`else
                end else begin
                    state_d = ST_REQ;
                end
`endif
            end
            ST_SERVICE: begin
                if (ERet) begin
                    state_d   = ST_IDLE;
                    estatus_d = 4'd0;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                estatus_d = 4'd0;
            end
        endcase

        // A new event on the bit being cleared wins, so it is never lost.
        pending_d = (pending_q & ~clr_s) | event_s;
        exc_d     = (state_d == ST_REQ);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            sel_q     <= 4'd0;
            estatus_q <= 4'd0;
            exc_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            estatus_q <= estatus_d;
            exc_q     <= exc_d;
            busy_q    <= busy_d;
        end
    end

`ifdef EXC_SOURCE_TIMEOUT_EN
    // REQ cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`endif

    assign Exc     = exc_q;
    assign EStatus = estatus_q;
    assign pending = pending_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_exc_source.sv
module tb_exc_source;

    localparam int NSRC    = 4;
    localparam int TIMEOUT = 16;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] irq;
    logic            ien;
    logic            ExcAck;
    logic            ERet;
    logic            Exc;
    logic [3:0]      EStatus;
    logic [NSRC-1:0] pending;
    logic            busy;
`ifdef EXC_SOURCE_TIMEOUT_EN
    logic            timeout_err;
`endif

    int n_checks;
    int n_errors;

    // Reference model: the active cause (0 = none) plus whether the core
    // has already acknowledged it.
    logic [NSRC-1:0] m_pend;
    logic [NSRC-1:0] m_irq_prev;
    int              m_cause;
    bit              m_acked;
    int              m_wait;
    bit              m_terr;

    exc_source #(.NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .ien     (ien),
        .ExcAck  (ExcAck),
        .ERet    (ERet),
        .Exc     (Exc),
        .EStatus (EStatus),
        .pending (pending),
        .busy    (busy)
`ifdef EXC_SOURCE_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend     = '0;
        m_irq_prev = '0;
        m_cause    = 0;
        m_acked    = 1'b0;
        m_wait     = 0;
        m_terr     = 1'b0;
    endtask

    // Advance the model by one clock given the inputs applied before the edge.
    task automatic model_step(input logic [NSRC-1:0] i_irq, input logic i_ien,
                              input logic i_ack, input logic i_eret);
        logic [NSRC-1:0] ev;
        logic [NSRC-1:0] clr;
        ev  = i_irq & ~m_irq_prev;
        clr = '0;
        if (m_cause == 0) begin
            if (i_ien && m_pend != '0) begin
                for (int i = 0; i < NSRC; i++) begin
                    if (m_pend[i] && m_cause == 0) m_cause = i + 1;
                end
                m_acked = 1'b0;
                m_wait  = 0;
            end
        end else if (!m_acked) begin
            if (i_ack) begin
                m_acked = 1'b1;
                clr[m_cause-1] = 1'b1;
            end else begin
`ifdef EXC_SOURCE_TIMEOUT_EN
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_cause = 0;
                    m_terr  = 1'b1;
                end
`endif
            end
        end else if (i_eret) begin
            m_cause = 0;
        end
        m_pend     = (m_pend & ~clr) | ev;
        m_irq_prev = i_irq;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".Exc"},     32'(Exc),     32'(m_cause != 0 && !m_acked));
        check_val({tag, ".EStatus"}, 32'(EStatus), 32'(m_cause));
        check_val({tag, ".pending"}, 32'(pending), 32'(m_pend));
        check_val({tag, ".busy"},    32'(busy),    32'(m_cause != 0));
`ifdef EXC_SOURCE_TIMEOUT_EN
        check_val({tag, ".terr"},    32'(timeout_err), 32'(m_terr));
`endif
    endtask

    // Called at a falling edge: apply inputs, run one clock, compare at the next falling edge.
    task automatic step(input string tag, input logic [NSRC-1:0] i_irq, input logic i_ien,
                        input logic i_ack, input logic i_eret);
        irq    = i_irq;
        ien    = i_ien;
        ExcAck = i_ack;
        ERet   = i_eret;
        model_step(i_irq, i_ien, i_ack, i_eret);
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_val("rst.Exc",     32'(Exc),     32'd0);
        check_val("rst.EStatus", 32'(EStatus), 32'd0);
        check_val("rst.pending", 32'(pending), 32'd0);
        check_val("rst.busy",    32'(busy),    32'd0);
`ifdef EXC_SOURCE_TIMEOUT_EN
        check_val("rst.terr",    32'(timeout_err), 32'd0);
`endif
        reset = 1'b1;
    endtask

    initial begin
        logic [NSRC-1:0] r_irq;
        n_checks = 0;
        n_errors = 0;
        irq      = '0;
        ien      = 1'b0;
        ExcAck   = 1'b0;
        ERet     = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        do_reset();

        // Single event on bit 2.
        step("t1.idle", 4'b0000, 1'b1, 1'b0, 1'b0);
        step("t1.edge", 4'b0100, 1'b1, 1'b0, 1'b0);
        check_val("t1.pend_set", 32'(pending), 32'h4);
        step("t1.req", 4'b0100, 1'b1, 1'b0, 1'b0);
        check_val("t1.exc_up", 32'(Exc), 32'd1);
        check_val("t1.cause3", 32'(EStatus), 32'd3);
        step("t1.hold", 4'b0100, 1'b1, 1'b0, 1'b0);
        step("t1.ack", 4'b0100, 1'b1, 1'b1, 1'b0);
        check_val("t1.exc_dn", 32'(Exc), 32'd0);
        check_val("t1.pend_clr", 32'(pending), 32'd0);
        for (int i = 0; i < 3; i++) step("t1.svc", 4'b0100, 1'b1, 1'b0, 1'b0);
        step("t1.eret", 4'b0100, 1'b1, 1'b0, 1'b1);
        check_val("t1.busy_dn", 32'(busy), 32'd0);
        check_val("t1.es_zero", 32'(EStatus), 32'd0);

        // Priority: bits 3 and 1 together, bit 0 arrives during service.
        step("t2.edge", 4'b1010, 1'b1, 1'b0, 1'b0);
        step("t2.req", 4'b1010, 1'b1, 1'b0, 1'b0);
        check_val("t2.first", 32'(EStatus), 32'd2);
        step("t2.ack", 4'b1010, 1'b1, 1'b1, 1'b0);
        step("t2.late", 4'b1011, 1'b1, 1'b0, 1'b0);
        check_val("t2.held", 32'(EStatus), 32'd2);
        step("t2.eret", 4'b1011, 1'b1, 1'b0, 1'b1);
        step("t2.next", 4'b1011, 1'b1, 1'b0, 1'b0);
        check_val("t2.late_wins", 32'(EStatus), 32'd1);

        // Simultaneous set and clear of pending[0].
        step("t3.drop", 4'b1010, 1'b1, 1'b0, 1'b0);
        step("t3.ackset", 4'b1011, 1'b1, 1'b1, 1'b0);
        check_val("t3.set_wins", 32'(pending[0]), 32'd1);
        step("t3.eret", 4'b1011, 1'b1, 1'b0, 1'b1);
        step("t3.again", 4'b1011, 1'b1, 1'b0, 1'b0);
        check_val("t3.reissue", 32'(EStatus), 32'd1);
        step("t3.ack2", 4'b1011, 1'b1, 1'b1, 1'b0);
        step("t3.eret2", 4'b1011, 1'b1, 1'b0, 1'b1);
        // Bit 3 is still pending; run it through with ien high.
        step("t3.req3", 4'b0000, 1'b1, 1'b0, 1'b0);
        check_val("t3.cause4", 32'(EStatus), 32'd4);
        step("t3.ack3", 4'b0000, 1'b1, 1'b1, 1'b0);
        step("t3.eret3", 4'b0000, 1'b1, 1'b0, 1'b1);

        // ien gating.
        step("t4.edge", 4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("t4.gated", 4'b0001, 1'b0, 1'b0, 1'b0);
            check_val("t4.no_exc", 32'(Exc), 32'd0);
        end
        step("t4.enable", 4'b0001, 1'b1, 1'b0, 1'b0);
        check_val("t4.exc_up", 32'(Exc), 32'd1);

        // Asynchronous reset while in REQ.
        reset = 1'b0;
        #1;
        check_val("t5.async_exc", 32'(Exc), 32'd0);
        check_val("t5.async_pend", 32'(pending), 32'd0);
        do_reset();

`ifdef EXC_SOURCE_TIMEOUT_EN
        // Unacknowledged request is withdrawn and retried.
        step("t6.edge", 4'b0010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT + 4; i++) step("t6.wait", 4'b0010, 1'b1, 1'b0, 1'b0);
        check_val("t6.terr", 32'(timeout_err), 32'd1);
        check_val("t6.pend_kept", 32'(pending), 32'h2);
        step("t6.ack", 4'b0010, 1'b1, 1'b1, 1'b0);
        step("t6.eret", 4'b0010, 1'b1, 1'b0, 1'b1);
`endif

        // Randomized traffic.
        r_irq = '0;
        for (int i = 0; i < 3000; i++) begin
            r_irq = r_irq ^ (NSRC'($urandom()) & NSRC'($urandom()));
            step("rnd", r_irq, ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
